// File: rtl/car_physics_pkg.sv
// car_pkg: fixed-point widths, FSM state encoding and map colour indices
// shared by car_physics, heading_lut and color_decoder.
package car_pkg;

    localparam int POS_INT   = 10;
    localparam int POS_FRAC  = 4;
    localparam int POS_W     = POS_INT + POS_FRAC;
    localparam int LUT_IDX_W = 5;

    localparam logic [3:0] GRASS_IDX = 4'd2;
    localparam logic [3:0] WALL_IDX  = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_MOVE,
        ST_RD,
        ST_WAIT,
        ST_CHK
    } state_t;

endpackage

// File: rtl/car_physics_heading_lut.sv
// heading_lut: sin/cos of a heading index (15-degree steps, 0..23) as
// signed Q1.7 values, built from one quarter-wave table.
module heading_lut
    import car_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic signed [7:0]    o_sin,
    output logic signed [7:0]    o_cos
);

    logic [LUT_IDX_W-1:0] w_cosIdx;

    function automatic logic signed [7:0] quarterSin(input logic [LUT_IDX_W-1:0] k);
        case (k)
            5'd0:    quarterSin = 8'sd0;
            5'd1:    quarterSin = 8'sd33;
            5'd2:    quarterSin = 8'sd64;
            5'd3:    quarterSin = 8'sd90;
            5'd4:    quarterSin = 8'sd110;
            5'd5:    quarterSin = 8'sd123;
            5'd6:    quarterSin = 8'sd127;
            default: quarterSin = 8'sd0;
        endcase
    endfunction

    // Fold the full circle onto the first quadrant by symmetry.
    function automatic logic signed [7:0] sinOf(input logic [LUT_IDX_W-1:0] k);
        if (k <= 5'd6)
            sinOf = quarterSin(k);
        else if (k <= 5'd12)
            sinOf = quarterSin(5'd12 - k);
        else if (k <= 5'd18)
            sinOf = -quarterSin(k - 5'd12);
        else
            sinOf = -quarterSin(5'd24 - k);
    endfunction

    assign w_cosIdx = (i_idx >= 5'd18) ? i_idx - 5'd18 : i_idx + 5'd6;
    assign o_sin    = sinOf(i_idx);
    assign o_cos    = sinOf(w_cosIdx);

endmodule

// File: rtl/car_physics.sv
// car_physics: per-player kinematics - steer, throttle, integrate, terrain check.
// Defining CAR_PHYSICS_REVERSE_EN enables a reverse gear on the brake button.
module car_physics
    import car_pkg::*;
#(
    parameter logic [9:0] X_INIT     = 10'd15,
    parameter logic [9:0] Y_INIT     = 10'd125,
    parameter logic [9:0] MAP_W      = 10'd320,
    parameter logic [9:0] MAP_H      = 10'd240,
    parameter logic [7:0] ACCEL      = 8'd2,
    parameter logic [7:0] FRICTION   = 8'd1,
    parameter logic [7:0] BRAKE      = 8'd4,
    parameter logic [7:0] MAX_SPEED  = 8'd48,
    parameter logic [8:0] STEER_STEP = 9'd15
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    output logic [16:0]        o_map_addr,
    output logic               o_map_rd,
    input  logic [3:0]         i_map_data,
    output logic [9:0]         o_world_x,
    output logic [9:0]         o_world_y,
    output logic [8:0]         o_degree,
    output logic signed [7:0]  o_speed,
    output logic               o_busy
);

    state_t               r_state, w_next;
    logic [POS_W-1:0]     r_posX, r_posY, r_candX, r_candY;
    logic [8:0]           r_deg;
    logic signed [7:0]    r_speed;
    logic                 r_grass;
    logic [16:0]          r_mapAddr;

    logic [8:0]           w_degNext;
    logic signed [9:0]    w_spdCur, w_cap, w_floor, w_fric, w_spdAdj;
    logic signed [7:0]    w_speedNext;
    logic [LUT_IDX_W-1:0] w_lutIdx;
    logic signed [7:0]    w_sin, w_cos;
    logic signed [15:0]   w_spdExt, w_sinExt, w_cosExt, w_prodX, w_prodY;
    logic signed [8:0]    w_dx, w_dy;
    logic signed [15:0]   w_cx, w_cy, w_xLim, w_yLim;
    logic [POS_W-1:0]     w_candX, w_candY;
    logic                 w_hit;
    logic [16:0]          w_addr;

    heading_lut u_lut (
        .i_idx (w_lutIdx),
        .o_sin (w_sin),
        .o_cos (w_cos)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_tick) w_next = ST_CTRL;
            ST_CTRL: w_next = ST_MOVE;
            ST_MOVE: w_next = ST_RD;
            ST_RD:   w_next = ST_WAIT;
            ST_WAIT: w_next = ST_CHK;
            ST_CHK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != ST_IDLE);
        o_map_rd = (r_state == ST_RD);
    end

    // Steering only bites while the car is already rolling.
    always_comb begin
        w_degNext = r_deg;
        if (r_speed != 8'sd0 && (i_left ^ i_right)) begin
            if (i_left)
                w_degNext = (r_deg < STEER_STEP) ? r_deg + 9'd360 - STEER_STEP : r_deg - STEER_STEP;
            else
                w_degNext = (r_deg + STEER_STEP >= 9'd360) ? r_deg + STEER_STEP - 9'd360 : r_deg + STEER_STEP;
        end
    end

    assign w_spdCur = {{2{r_speed[7]}}, r_speed};
    assign w_fric   = $signed({2'b00, FRICTION});
    assign w_cap    = r_grass ? $signed({3'b000, MAX_SPEED[7:1]}) : $signed({2'b00, MAX_SPEED});
`ifdef CAR_PHYSICS_REVERSE_EN
    assign w_floor  = -$signed({3'b000, MAX_SPEED[7:1]});
`else
    assign w_floor  = '0;
`endif

    always_comb begin
        w_spdAdj = w_spdCur;
        if (i_down)
            w_spdAdj = w_spdCur - $signed({2'b00, BRAKE});
        else if (i_up)
            w_spdAdj = w_spdCur + $signed({2'b00, ACCEL});
        else if (w_spdCur > w_fric)
            w_spdAdj = w_spdCur - w_fric;
        else if (w_spdCur < -w_fric)
            w_spdAdj = w_spdCur + w_fric;
        else
            w_spdAdj = '0;
        if (w_spdAdj > w_cap)
            w_spdAdj = w_cap;
        else if (w_spdAdj < w_floor)
            w_spdAdj = w_floor;
        w_speedNext = w_spdAdj[7:0];
    end

    // Deltas are in 1/16 px; the slice of bits [15:7] is an arithmetic >>> 7.
    assign w_lutIdx = LUT_IDX_W'(r_deg / STEER_STEP);
    assign w_spdExt = {{8{r_speed[7]}}, r_speed};
    assign w_sinExt = {{8{w_sin[7]}}, w_sin};
    assign w_cosExt = {{8{w_cos[7]}}, w_cos};
    assign w_prodX  = w_spdExt * w_sinExt;
    assign w_prodY  = -(w_spdExt * w_cosExt);
    assign w_dx     = w_prodX[15:7];
    assign w_dy     = w_prodY[15:7];
    assign w_cx     = $signed({2'b00, r_posX}) + $signed({{7{w_dx[8]}}, w_dx});
    assign w_cy     = $signed({2'b00, r_posY}) + $signed({{7{w_dy[8]}}, w_dy});
    assign w_xLim   = $signed({2'b00, MAP_W, {POS_FRAC{1'b0}}});
    assign w_yLim   = $signed({2'b00, MAP_H, {POS_FRAC{1'b0}}});

    always_comb begin
        w_hit   = 1'b0;
        w_candX = w_cx[POS_W-1:0];
        w_candY = w_cy[POS_W-1:0];
        if (w_cx[15]) begin
            w_candX = '0;
            w_hit   = 1'b1;
        end else if (w_cx >= w_xLim) begin
            w_candX = {MAP_W - 10'd1, {POS_FRAC{1'b0}}};
            w_hit   = 1'b1;
        end
        if (w_cy[15]) begin
            w_candY = '0;
            w_hit   = 1'b1;
        end else if (w_cy >= w_yLim) begin
            w_candY = {MAP_H - 10'd1, {POS_FRAC{1'b0}}};
            w_hit   = 1'b1;
        end
    end

    assign w_addr = 17'(w_candY[POS_W-1:POS_FRAC]) * 17'(MAP_W) + 17'(w_candX[POS_W-1:POS_FRAC]);

    // Position only moves in CHK, so a reset mid-update never half-commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_posX    <= {X_INIT, {POS_FRAC{1'b0}}};
            r_posY    <= {Y_INIT, {POS_FRAC{1'b0}}};
            r_candX   <= '0;
            r_candY   <= '0;
            r_deg     <= '0;
            r_speed   <= '0;
            r_grass   <= 1'b0;
            r_mapAddr <= '0;
        end else begin
            case (r_state)
                ST_CTRL: begin
                    r_deg   <= w_degNext;
                    r_speed <= w_speedNext;
                end
                ST_MOVE: begin
                    r_candX   <= w_candX;
                    r_candY   <= w_candY;
                    r_mapAddr <= w_addr;
                    if (w_hit)
                        r_speed <= '0;
                end
                ST_CHK: begin
                    if (i_map_data == WALL_IDX) begin
                        r_speed <= '0;
                    end else begin
                        r_posX  <= r_candX;
                        r_posY  <= r_candY;
                        r_grass <= (i_map_data == GRASS_IDX);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_map_addr = r_mapAddr;
    assign o_world_x  = r_posX[POS_W-1:POS_FRAC];
    assign o_world_y  = r_posY[POS_W-1:POS_FRAC];
    assign o_degree   = r_deg;
    assign o_speed    = r_speed;

endmodule

// File: tb/tb_car_physics.sv
// tb_car_physics: directed and randomized checks of car_physics against a
// behavioural kinematics model. Honours CAR_PHYSICS_REVERSE_EN.
module tb_car_physics;

    localparam int MAP_W = 320;
    localparam int MAP_H = 240;
    localparam int WALL  = 5;
    localparam int GRASS = 2;
`ifdef CAR_PHYSICS_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int deg;
        int spd;
        bit grass;
    } carState_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [16:0] mapAddr;
    logic        mapRd;
    logic [3:0]  mapData = 4'd0;
    logic [9:0]  worldX, worldY;
    logic [8:0]  degree;
    logic [7:0]  speed;
    logic        busy;

    logic [3:0]  mem [0:MAP_W*MAP_H-1];
    logic [16:0] lastAddr = '0;
    int          rdCount = 0;
    int          checks = 0;
    int          errors = 0;
    carState_t   m;
    int          expAddr;

    car_physics dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tick     (tick),
        .i_up       (up),
        .i_down     (down),
        .i_left     (left),
        .i_right    (right),
        .o_map_addr (mapAddr),
        .o_map_rd   (mapRd),
        .i_map_data (mapData),
        .o_world_x  (worldX),
        .o_world_y  (worldY),
        .o_degree   (degree),
        .o_speed    (speed),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    // Map BRAM model: registered read, output held between reads.
    always @(posedge clk) begin
        if (mapRd) begin
            mapData  <= mem[mapAddr];
            lastAddr <= mapAddr;
            rdCount  <= rdCount + 1;
        end
    end

    function automatic int sinDeg(input int d);
        int t[7] = '{0, 33, 64, 90, 110, 123, 127};
        int a;
        a = ((d % 360) + 360) % 360;
        if (a <= 90)       return t[a / 15];
        else if (a <= 180) return t[(180 - a) / 15];
        else if (a <= 270) return -t[(a - 180) / 15];
        else               return -t[(360 - a) / 15];
    endfunction

    // One frame of car physics, straight from the game rules.
    function automatic void step(input carState_t s, input bit u, input bit d, input bit l,
                                 input bit r, output carState_t n, output int addr);
        int cap, lo, dx, dy, cx, cy;
        bit hit;
        n = s;
        if (s.spd != 0 && l != r)
            n.deg = l ? (s.deg + 345) % 360 : (s.deg + 15) % 360;
        cap = s.grass ? 24 : 48;
        lo  = REV ? -24 : 0;
        if (d)              n.spd = s.spd - 4;
        else if (u)         n.spd = s.spd + 2;
        else if (s.spd > 0) n.spd = (s.spd > 1) ? s.spd - 1 : 0;
        else if (s.spd < 0) n.spd = (s.spd < -1) ? s.spd + 1 : 0;
        if (n.spd > cap) n.spd = cap;
        if (n.spd < lo)  n.spd = lo;
        dx  = (n.spd * sinDeg(n.deg)) >>> 7;
        dy  = (-(n.spd * sinDeg(n.deg + 90))) >>> 7;
        cx  = s.x + dx;
        cy  = s.y + dy;
        hit = 1'b0;
        if (cx < 0) begin cx = 0; hit = 1'b1; end
        else if (cx >= MAP_W * 16) begin cx = (MAP_W - 1) * 16; hit = 1'b1; end
        if (cy < 0) begin cy = 0; hit = 1'b1; end
        else if (cy >= MAP_H * 16) begin cy = (MAP_H - 1) * 16; hit = 1'b1; end
        if (hit) n.spd = 0;
        addr = (cy / 16) * MAP_W + cx / 16;
        if (int'(mem[addr]) == WALL) begin
            n.spd = 0;
        end else begin
            n.x     = cx;
            n.y     = cy;
            n.grass = (int'(mem[addr]) == GRASS);
        end
    endfunction

    task automatic checkValue(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".x"},     worldX, m.x / 16);
        checkValue({tag, ".y"},     worldY, m.y / 16);
        checkValue({tag, ".deg"},   degree, m.deg);
        checkValue({tag, ".speed"}, $signed(speed), m.spd);
        checkValue({tag, ".addr"},  lastAddr, expAddr);
    endtask

    task automatic checkResetState(input string tag);
        checkValue({tag, ".x"},     worldX, 15);
        checkValue({tag, ".y"},     worldY, 125);
        checkValue({tag, ".deg"},   degree, 0);
        checkValue({tag, ".speed"}, $signed(speed), 0);
        checkValue({tag, ".busy"},  busy, 0);
        checkValue({tag, ".rd"},    mapRd, 0);
        checkValue({tag, ".addr"},  mapAddr, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m = '{x: 15 * 16, y: 125 * 16, deg: 0, spd: 0, grass: 1'b0};
    endtask

    task automatic clearMap();
        for (int i = 0; i < MAP_W * MAP_H; i++) mem[i] = 4'd0;
    endtask

    // One full frame update with buttons held throughout, then model check.
    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input string tag);
        int cyc;
        int rdBase;
        carState_t nxt;
        up = u; down = d; left = l; right = r;
        rdBase = rdCount;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkValue({tag, ".len"}, cyc, 5);
        checkValue({tag, ".rds"}, rdCount - rdBase, 1);
        step(m, u, d, l, r, nxt, expAddr);
        m = nxt;
        checkOutput(tag);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc, rdBase, wallAddr, sx, sy;
        carState_t tmp;

        clearMap();
        @(posedge clk); #1;
        doReset();
        checkResetState("reset");

        $display("[TB] throttle");
        repeat (4) applyStimulus(1, 0, 0, 0, "throttle");
        checkValue("throttle.speed8", $signed(speed), 8);
        checkValue("throttle.xSame", worldX, 15);

        $display("[TB] heading wrap");
        applyStimulus(0, 0, 1, 0, "left");
        checkValue("wrap.left", degree, 345);
        applyStimulus(0, 0, 0, 1, "right");
        checkValue("wrap.right", degree, 0);
        applyStimulus(0, 0, 1, 1, "both");
        checkValue("wrap.both", degree, 0);

        $display("[TB] wall");
        step(m, 1, 0, 0, 0, tmp, wallAddr);
        mem[wallAddr] = 4'(WALL);
        sx = m.x / 16;
        sy = m.y / 16;
        applyStimulus(1, 0, 0, 0, "wall");
        checkValue("wall.x", worldX, sx);
        checkValue("wall.y", worldY, sy);
        checkValue("wall.speed", $signed(speed), 0);
        checkValue("wall.addr", lastAddr, wallAddr);
        mem[wallAddr] = 4'd0;

        $display("[TB] busy drop");
        up = 1; down = 0; left = 0; right = 0;
        rdBase = rdCount;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            tick = (cyc == 1);
            @(posedge clk); #1;
            cyc++;
        end
        tick = 1'b0;
        checkValue("drop.busyFall", cyc, 5);
        repeat (8) @(posedge clk);
        #1;
        checkValue("drop.idle", busy, 0);
        checkValue("drop.oneRead", rdCount - rdBase, 1);
        step(m, 1, 0, 0, 0, tmp, expAddr);
        m = tmp;
        checkOutput("drop");

        $display("[TB] reset abort");
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        doReset();
        checkResetState("abort");

        $display("[TB] edge clamp");
        applyStimulus(1, 0, 0, 0, "edge");
        repeat (6) applyStimulus(1, 0, 1, 0, "edgeSteer");
        checkValue("edge.deg", degree, 270);
        repeat (25) applyStimulus(1, 0, 0, 0, "edgeRun");
        checkValue("edge.x0", worldX, 0);
        checkValue("edge.speed0", $signed(speed), 0);

        $display("[TB] reverse");
        doReset();
        repeat (3) applyStimulus(0, 1, 0, 0, "reverse");
        checkValue("reverse.speed", $signed(speed), REV ? -12 : 0);

        $display("[TB] random");
        for (int i = 0; i < MAP_W * MAP_H; i++) begin
            int p;
            p = $urandom_range(0, 99);
            mem[i] = (p < 4) ? 4'(WALL) : (p < 14) ? 4'(GRASS) : 4'd0;
        end
        doReset();
        for (int n = 0; n < 150; n++) begin
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
